// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a 32-bit big-endian word stream into 512-bit chunks,
// appending the 0x80 marker, zero fill and the 64-bit bit-length field.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         chunk_valid,
  input  logic         chunk_ready,
  output logic [511:0] chunk,
  output logic         chunk_last
);

  typedef enum logic [1:0] {FILL, EMIT, EMIT_PRE} state_t;

  state_t             state, next_state;
  logic [3:0]         idx;
  logic [60:0]        byte_cnt;
  logic [31:0]        buffer [16];
  logic               pend_p16;

  logic               accept;
  logic [2:0]         b_eff;
  logic [60:0]        cnt_next;
  logic [LEN_W-1:0]   msg_len;
  logic [31:0]        masked_word;
  logic [31:0]        word_in;
  logic [4:0]         marker_pos;
  logic               final_fits;
  logic [31:0]        fill_buf [16];
  logic [511:0]       fill_packed;
  logic [511:0]       extra_packed;

  assign in_ready = (state == FILL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    b_eff       = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    cnt_next    = byte_cnt + (in_last ? 61'(b_eff) : 61'd4);
    msg_len     = {cnt_next, 3'b000};
    masked_word = in_data;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) == b_eff)
        masked_word[31-8*j -: 8] = 8'h80;
      else if (3'(j) > b_eff)
        masked_word[31-8*j -: 8] = 8'h00;
    end
    word_in    = in_last ? masked_word : in_data;
    marker_pos = (b_eff == 3'd4) ? ({1'b0, idx} + 5'd1) : {1'b0, idx};
    final_fits = in_last && (marker_pos <= 5'd13);
  end

  // Build the chunk image as it would look after writing the incoming word
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      fill_buf[i] = buffer[i];
      if (4'(i) == idx)
        fill_buf[i] = word_in;
      else if (in_last && (4'(i) > idx))
        fill_buf[i] = (5'(i) == marker_pos) ? 32'h8000_0000 : 32'h0;
    end
    if (final_fits) begin
      fill_buf[14] = msg_len[63:32];
      fill_buf[15] = msg_len[31:0];
    end
    fill_packed = '0;
    for (int i = 0; i < 16; i++)
      fill_packed[511-32*i -: 32] = fill_buf[i];
    extra_packed = {(pend_p16 ? 32'h8000_0000 : 32'h0), 416'd0, byte_cnt, 3'b000};
  end

  always_ff @(posedge clock) begin
    if (!reset)
      state <= FILL;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FILL: begin
        if (accept) begin
          if (in_last)
            next_state = final_fits ? EMIT : EMIT_PRE;
          else if (idx == 4'd15)
            next_state = EMIT;
        end
      end
      EMIT:     if (chunk_ready) next_state = FILL;
      EMIT_PRE: if (chunk_ready) next_state = EMIT;
      default:  next_state = FILL;
    endcase
  end

  // The byte counter survives intermediate chunks and clears only after the length is sent
  always_ff @(posedge clock) begin
    if (!reset) begin
      idx         <= '0;
      byte_cnt    <= '0;
      chunk       <= '0;
      chunk_valid <= 1'b0;
      chunk_last  <= 1'b0;
      pend_p16    <= 1'b0;
      for (int i = 0; i < 16; i++) buffer[i] <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            for (int i = 0; i < 16; i++) buffer[i] <= fill_buf[i];
            byte_cnt <= cnt_next;
            if (in_last || (idx == 4'd15)) begin
              chunk       <= fill_packed;
              chunk_valid <= 1'b1;
              chunk_last  <= final_fits;
              pend_p16    <= (marker_pos == 5'd16);
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        EMIT: begin
          if (chunk_ready) begin
            chunk_valid <= 1'b0;
            idx         <= '0;
            for (int i = 0; i < 16; i++) buffer[i] <= '0;
            if (chunk_last) byte_cnt <= '0;
          end
        end
        EMIT_PRE: begin
          if (chunk_ready) begin
            chunk      <= extra_packed;
            chunk_last <= 1'b1;
            idx        <= '0;
            for (int i = 0; i < 16; i++) buffer[i] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
Upstream stage of the SHA-256 compression block. It receives an arbitrary-length message as a stream of 32-bit big-endian words and applies standard SHA-256 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. It emits the result as a sequence of 512-bit chunks over a valid/ready handshake. In the miner it pads the 80-byte block header (with nonce already inserted) before it reaches the compression logic.

Parameters:
LEN_W, 64, width of the appended bit-length field. Fixed by SHA-256; not to be overridden.

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-low
in_valid  input  1  in_data/in_last/in_bytes valid
in_ready  output  1  padder accepts a word this cycle
in_data  input  32  message word, first byte in [31:24]
in_last  input  1  final word of the message
in_bytes  input  3  valid bytes in the final word, 0..4; values 5..7 are treated as 4; ignored when in_last=0
chunk_valid  output  1  chunk is valid
chunk_ready  input  1  downstream consumes the chunk
chunk  output  512  padded block, word 0 in [511:480]
chunk_last  output  1  this chunk carries the length field (end of message)

Behaviour:
- Reset (reset=0 at posedge): state=FILL; word index idx=0; byte counter=0; buffer=0; chunk=0; chunk_valid=0; chunk_last=0. Reset overrides any operation in progress, including a pending chunk. The partial message is discarded.
- in_ready is a combinational decode: in_ready = (state==FILL). It is 1 from the first cycle after reset.
- Word accepted when in_valid && in_ready. The word is written to buffer word idx. The byte counter adds 4, or in_bytes if in_last.
- Byte counter is 61 bits. Length field = {counter,3'b000}, wrapping mod 2^64.
- FILL, non-last word at idx<15: idx increments.
- FILL, non-last word at idx=15: next state EMIT. chunk is loaded from the buffer; chunk_valid=1; chunk_last=0.
- FILL, last word with b=in_bytes at idx k:
  - Bytes b..3 of the word are zeroed.
  - If b<4: byte b is set to 0x80 and marker position p=k.
  - If b=4: p=k+1. If p<=15, word p is set to 0x80000000.
  - Words above p (up to 15) are zeroed.
- Final-chunk decision:
  - p<=13: words 14/15 = length[63:32]/[31:0]. Emit with chunk_last=1; next state EMIT.
  - p in {14,15,16}: emit the current buffer with chunk_last=0; next state EMIT_PRE.
- EMIT: chunk and chunk_last are held stable while chunk_ready=0. On chunk_valid && chunk_ready: chunk_valid=0; buffer cleared; idx=0; state=FILL. The byte counter clears only if chunk_last=1.
- EMIT_PRE: on handshake, load the extra chunk and stay valid next cycle with chunk_last=1; state=EMIT.
  - Extra chunk: word0 = 0x80000000 if p=16, else 0. Words 1..13 = 0. Words 14/15 = length.
- Latency: the chunk is valid the cycle after the accepting edge. The extra chunk is valid the cycle after the pre-final handshake.
- Throughput: one word per cycle in FILL. Minimum one cycle per chunk in EMIT, since in_ready=0 while a chunk is pending.
- Empty message (in_last with in_bytes=0 at idx 0) is legal. It produces a single 0x80 chunk with length 0.
- in_valid with in_ready=0 is ignored. The source must hold the word.

Test Plan:
1. "abc": in_data=0x61626300, in_last=1, in_bytes=3, chunk_ready=1.
   Required: one chunk 0x61626380, 13 zero words, 0x00000000, 0x00000018; chunk_last=1.
   Passing it to the compression stage yields ba7816bf...f20015ad.
2. Empty message: in_last=1, in_bytes=0.
   Required: chunk 0x80000000 followed by zeros, length 0; chunk_last=1.
3. 56 bytes (14 full words, last in_bytes=4): p=14.
   Required chunk 1: data words 0..13, word14=0x80000000, word15=0, chunk_last=0.
   Required chunk 2: all zero except word15=0x000001C0, chunk_last=1.
4. 64 bytes (16 full words): p=16.
   Required chunk 1: pure data, chunk_last=0.
   Required chunk 2: word0=0x80000000, word15=0x00000200, chunk_last=1.
5. 80-byte header (20 words):
   Required chunk 1: data, chunk_last=0.
   Required chunk 2: words 0..3 data, word4=0x80000000, word15=0x00000280, chunk_last=1.
   Hold chunk_ready=0 for 5 cycles on each chunk: chunk must stay bit-stable, in_ready=0, and no input word may be lost.
6. Reset after 7 accepted words, then "abc":
   Required: chunk_valid=0 and in_ready=1 the cycle after reset. Output equals scenario 1; the length is not polluted by the 7 discarded words.
